// File: rtl/frame_dump_sequencer_pkg.sv
// Shared types and constants for the frame dump sequencer.
package frame_dump_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_WAIT_LINE,
        ST_FETCH,
        ST_SEND,
        ST_GUARD,
        ST_NEXT,
        ST_TRL,
        ST_DONE
    } state_t;

    localparam logic [7:0] CMD_FULL     = 8'h46;
    localparam logic [7:0] CMD_DECIM    = 8'h44;
    localparam logic [7:0] CMD_ABORT    = 8'h1B;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
    localparam logic [7:0] TRL_BYTE_DEF = 8'h5A;

    localparam int unsigned RX_W        = 8;
    localparam int unsigned TX_W        = 8;
    localparam int unsigned BUF_DATA_W  = 10;

    // Index width for a counter running 0..n-1, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/frame_dump_sequencer_if.sv
// UART and line-buffer signals seen by the frame dump sequencer.
interface frame_dump_sequencer_if #(
    parameter int unsigned LINE_COUNT  = 752,
    parameter int unsigned LINE_LENGTH = 480
);
    import frame_dump_sequencer_pkg::*;

    localparam int unsigned LW = idx_width(LINE_COUNT);
    localparam int unsigned CW = idx_width(LINE_LENGTH);

    logic [RX_W-1:0]       RX_DATA;
    logic                  RX_READY;
    logic                  TX_IDLE;
    logic [TX_W-1:0]       TX_DATA;
    logic                  TX_DATA_READY;
    logic                  BUF_READY;
    logic [BUF_DATA_W-1:0] BUF_DATA;
    logic                  BUF_RESET_READY;
    logic [LW-1:0]         SEL_LINE;
    logic [CW-1:0]         SEL_COLUMN;
    logic                  BUSY;

    // Sequencer side.
    modport master (
        input  RX_DATA, RX_READY, TX_IDLE, BUF_READY, BUF_DATA,
        output TX_DATA, TX_DATA_READY, BUF_RESET_READY, SEL_LINE, SEL_COLUMN, BUSY
    );

    // UART / line-buffer side.
    modport slave (
        output RX_DATA, RX_READY, TX_IDLE, BUF_READY, BUF_DATA,
        input  TX_DATA, TX_DATA_READY, BUF_RESET_READY, SEL_LINE, SEL_COLUMN, BUSY
    );

endinterface

// File: rtl/frame_dump_sequencer.sv
// Command-driven frame dump: walks the line buffer and streams header,
// pixel MSBs and trailer out through uart_send one byte at a time.
module frame_dump_sequencer
    import frame_dump_sequencer_pkg::*;
#(
    parameter int unsigned LINE_COUNT  = 752,
    parameter int unsigned LINE_LENGTH = 480,
    parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEF,
    parameter logic [7:0]  TRL_BYTE    = TRL_BYTE_DEF
) (
    input logic CLK,
    input logic RST,
    frame_dump_sequencer_if.master bus
);

    localparam int unsigned LW = idx_width(LINE_COUNT);
    localparam int unsigned CW = idx_width(LINE_LENGTH);

    state_t          state_q;
    state_t          ret_q;
    logic            decim_q;
    logic            abort_q;
    logic            rx_ready_q;
    logic [TX_W-1:0] tx_data_q;
    logic            tx_strobe_q;
    logic            brr_q;
    logic [LW-1:0]   line_q;
    logic [CW-1:0]   col_q;
    logic            busy_q;

    logic            rx_new_c;
    logic            abort_c;
    logic            cmd_ok_c;
    logic [CW:0]     col_sum_c;
    logic [LW:0]     line_sum_c;
    logic            unused_buf_lsbs_c;

    // Byte arrival, command decode and one-bit-wide-headroom index sums.
    assign rx_new_c   = bus.RX_READY & ~rx_ready_q;
    assign cmd_ok_c   = (bus.RX_DATA == CMD_FULL) || (bus.RX_DATA == CMD_DECIM);
    assign abort_c    = rx_new_c && (bus.RX_DATA == CMD_ABORT) && (state_q != ST_IDLE);
    assign col_sum_c  = {1'b0, col_q}  + (decim_q ? (CW+1)'(2) : (CW+1)'(1));
    assign line_sum_c = {1'b0, line_q} + (decim_q ? (LW+1)'(2) : (LW+1)'(1));

    // Only the top eight bits of a pixel are transmitted.
    assign unused_buf_lsbs_c = ^bus.BUF_DATA[1:0];

    // Dump sequencer; every output is a register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            decim_q     <= 1'b0;
            abort_q     <= 1'b0;
            rx_ready_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_strobe_q <= 1'b0;
            brr_q       <= 1'b1;
            line_q      <= '0;
            col_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            rx_ready_q  <= bus.RX_READY;
            tx_strobe_q <= 1'b0;
            if (abort_c) begin
                abort_q <= 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    brr_q <= 1'b1;
                    if (rx_new_c && cmd_ok_c) begin
                        decim_q <= (bus.RX_DATA == CMD_DECIM);
                        abort_q <= 1'b0;
                        line_q  <= '0;
                        col_q   <= '0;
                        brr_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (bus.TX_IDLE) begin
                        tx_data_q   <= HDR_BYTE;
                        tx_strobe_q <= 1'b1;
                        ret_q       <= ST_WAIT_LINE;
                        state_q     <= ST_GUARD;
                    end
                end
                ST_WAIT_LINE: begin
                    // Ends the one-cycle re-arm pulse issued at a line step.
                    brr_q <= 1'b0;
                    if (bus.BUF_READY) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.TX_IDLE) begin
                        tx_data_q   <= bus.BUF_DATA[BUF_DATA_W-1 -: TX_W];
                        tx_strobe_q <= 1'b1;
                        ret_q       <= ST_NEXT;
                        state_q     <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    // uart_send may still show IDLE here, so it is not looked at.
                    if (abort_q || abort_c) begin
                        abort_q <= 1'b0;
                        busy_q  <= 1'b0;
                        line_q  <= '0;
                        col_q   <= '0;
                        brr_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ret_q;
                    end
                end
                ST_NEXT: begin
                    if (col_sum_c < (CW+1)'(LINE_LENGTH)) begin
                        col_q   <= col_sum_c[CW-1:0];
                        state_q <= ST_FETCH;
                    end else if (line_sum_c < (LW+1)'(LINE_COUNT)) begin
                        col_q   <= '0;
                        line_q  <= line_sum_c[LW-1:0];
                        brr_q   <= 1'b1;
                        state_q <= ST_WAIT_LINE;
                    end else begin
                        state_q <= ST_TRL;
                    end
                end
                ST_TRL: begin
                    if (bus.TX_IDLE) begin
                        tx_data_q   <= TRL_BYTE;
                        tx_strobe_q <= 1'b1;
                        ret_q       <= ST_DONE;
                        state_q     <= ST_GUARD;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    line_q  <= '0;
                    col_q   <= '0;
                    brr_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output drive from the registers above.
    assign bus.TX_DATA         = tx_data_q;
    assign bus.TX_DATA_READY   = tx_strobe_q;
    assign bus.BUF_RESET_READY = brr_q;
    assign bus.SEL_LINE        = line_q;
    assign bus.SEL_COLUMN      = col_q;
    assign bus.BUSY            = busy_q;

endmodule

// File: tb/tb_frame_dump_sequencer.sv
// Self-checking bench for frame_dump_sequencer on a 4x3 frame.
module tb_frame_dump_sequencer;
    import frame_dump_sequencer_pkg::*;

    localparam int unsigned LC = 4;
    localparam int unsigned LL = 3;
    localparam int unsigned LW = idx_width(LC);
    localparam int unsigned CW = idx_width(LL);

    typedef struct {
        logic [7:0] cmd;
        bit         rand_ready;
        int         exp_bytes;
        int         exp_brr;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    frame_dump_sequencer_if #(.LINE_COUNT(LC), .LINE_LENGTH(LL)) bus ();

    frame_dump_sequencer #(
        .LINE_COUNT (LC),
        .LINE_LENGTH(LL),
        .HDR_BYTE   (8'hA5),
        .TRL_BYTE   (8'h5A)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         idle_cnt = 0;
    logic       rand_bit = 1'b0;
    bit         ready_mode = 1'b0;
    logic       buf_level = 1'b1;
    int         brr_pulses = 0;
    logic       prev_strobe = 1'b0;
    logic       prev_brr = 1'b0;
    vec_t       tbl[6];

    assign bus.TX_IDLE   = (idle_cnt == 0);
    assign bus.BUF_READY = ready_mode ? rand_bit : buf_level;

    // uart_send stand-in: busy for a random number of cycles after each strobe.
    always @(posedge CLK) begin
        rand_bit <= 1'($urandom_range(0, 1));
        if (RST)                    idle_cnt <= 0;
        else if (bus.TX_DATA_READY) idle_cnt <= int'($urandom_range(1, 6));
        else if (idle_cnt != 0)     idle_cnt <= idle_cnt - 1;
    end

    // Line buffer stand-in: pixel value encodes its own coordinates.
    always @(posedge CLK) begin
        bus.BUF_DATA <= 10'({bus.SEL_LINE, bus.SEL_COLUMN, 2'b00});
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmit monitor.
    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.TX_DATA_READY) begin
                check("strobe_when_idle", 32'(bus.TX_IDLE), 1);
                check("back_to_back_strobe", 32'(prev_strobe), 0);
                got.push_back(bus.TX_DATA);
            end
            if (bus.BUSY && bus.BUF_RESET_READY && !prev_brr) brr_pulses <= brr_pulses + 1;
        end
        prev_strobe <= bus.TX_DATA_READY;
        prev_brr    <= bus.BUF_RESET_READY;
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.RX_DATA  = b;
        bus.RX_READY = 1'b1;
        tick();
        tick();
        bus.RX_READY = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.BUSY && n < budget) begin
            tick();
            n++;
        end
        check("dump_completes", 32'(bus.BUSY), 0);
    endtask

    // Reference stream: header, every step-th pixel of every step-th line, trailer.
    task automatic build_exp(input logic [7:0] cmd);
        int step;
        exp_q.delete();
        if (cmd == 8'h46)      step = 1;
        else if (cmd == 8'h44) step = 2;
        else                   return;
        exp_q.push_back(8'hA5);
        for (int l = 0; l < int'(LC); l += step)
            for (int c = 0; c < int'(LL); c += step)
                exp_q.push_back(8'((l << CW) | c));
        exp_q.push_back(8'h5A);
    endtask

    task automatic compare_stream(input string name);
        check({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int mark;
        bit seen_trl;
        logic [7:0] cmd;

        bus.RX_DATA  = 8'h00;
        bus.RX_READY = 1'b0;
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;

        // Reset state held across idle cycles.
        got.delete();
        repeat (10) tick();
        check("rst_busy", 32'(bus.BUSY), 0);
        check("rst_brr", 32'(bus.BUF_RESET_READY), 1);
        check("rst_tx_data", 32'(bus.TX_DATA), 0);
        check("rst_sel_line", 32'(bus.SEL_LINE), 0);
        check("rst_sel_col", 32'(bus.SEL_COLUMN), 0);
        check("rst_no_strobe", got.size(), 0);

        // Table-driven commands.
        tbl[0] = '{8'h46, 1'b0, 14, 3};
        tbl[1] = '{8'h44, 1'b0, 6, 1};
        tbl[2] = '{8'h58, 1'b0, 0, 0};
        tbl[3] = '{8'h1B, 1'b0, 0, 0};
        tbl[4] = '{8'h46, 1'b1, 14, 3};
        tbl[5] = '{8'h44, 1'b1, 6, 1};
        for (int i = 0; i < 6; i++) begin
            ready_mode = tbl[i].rand_ready;
            buf_level  = 1'b1;
            got.delete();
            base = brr_pulses;
            send_byte(tbl[i].cmd);
            wait_idle(2000);
            repeat (4) tick();
            build_exp(tbl[i].cmd);
            check($sformatf("vec%0d_bytes", i), got.size(), tbl[i].exp_bytes);
            compare_stream($sformatf("vec%0d", i));
            check($sformatf("vec%0d_brr_pulses", i), brr_pulses - base, tbl[i].exp_brr);
            check($sformatf("vec%0d_brr_idle", i), 32'(bus.BUF_RESET_READY), 1);
            if (tbl[i].exp_bytes != 0)
                check($sformatf("vec%0d_tx_hold", i), 32'(bus.TX_DATA), 32'h5A);
        end

        // Stall on BUF_READY at the start of line 1.
        ready_mode = 1'b0;
        buf_level  = 1'b1;
        got.delete();
        send_byte(8'h46);
        n = 0;
        while (bus.SEL_LINE != 2'(1) && n < 1000) begin
            tick();
            n++;
        end
        buf_level = 1'b0;
        check("stall_reach_line1", 32'(bus.SEL_LINE), 1);
        mark = got.size();
        repeat (50) tick();
        check("stall_no_strobe", got.size(), mark);
        check("stall_busy", 32'(bus.BUSY), 1);
        buf_level = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (got.size() == mark) tick();
        end
        check("stall_resume_3cyc", 32'(got.size() > mark), 1);
        if (got.size() > mark)
            check("stall_resume_pixel", 32'(got[mark]), 32'(1 << CW));
        wait_idle(2000);
        build_exp(8'h46);
        compare_stream("stall");

        // Abort after the fifth pixel.
        got.delete();
        send_byte(8'h46);
        n = 0;
        while (got.size() < 6 && n < 1000) begin
            tick();
            n++;
        end
        check("abort_reach_px5", 32'(got.size() >= 6), 1);
        send_byte(8'h1B);
        wait_idle(500);
        repeat (10) tick();
        check("abort_extra_px", 32'(got.size() <= 7), 1);
        seen_trl = 1'b0;
        foreach (got[i]) if (got[i] == 8'h5A) seen_trl = 1'b1;
        check("abort_no_trl", 32'(seen_trl), 0);
        check("abort_busy", 32'(bus.BUSY), 0);
        got.delete();
        send_byte(8'h58);
        repeat (20) tick();
        check("post_abort_x_busy", 32'(bus.BUSY), 0);
        check("post_abort_x_bytes", got.size(), 0);
        send_byte(8'h46);
        wait_idle(2000);
        repeat (4) tick();
        build_exp(8'h46);
        compare_stream("post_abort_f");

        // Reset in the middle of line 2.
        got.delete();
        send_byte(8'h46);
        n = 0;
        while (bus.SEL_LINE != 2'(2) && n < 1000) begin
            tick();
            n++;
        end
        check("rst_reach_line2", 32'(bus.SEL_LINE), 2);
        RST = 1'b1;
        tick();
        check("mid_rst_tx_data", 32'(bus.TX_DATA), 0);
        check("mid_rst_strobe", 32'(bus.TX_DATA_READY), 0);
        check("mid_rst_brr", 32'(bus.BUF_RESET_READY), 1);
        check("mid_rst_sel_line", 32'(bus.SEL_LINE), 0);
        check("mid_rst_sel_col", 32'(bus.SEL_COLUMN), 0);
        check("mid_rst_busy", 32'(bus.BUSY), 0);
        RST = 1'b0;
        got.delete();
        repeat (30) tick();
        check("post_rst_no_strobe", got.size(), 0);
        check("post_rst_busy", 32'(bus.BUSY), 0);

        // Randomized commands, ready patterns and uart_send latency.
        for (int r = 0; r < 8; r++) begin
            case ($urandom_range(0, 3))
                0:       cmd = 8'h46;
                1:       cmd = 8'h44;
                2:       cmd = 8'h58;
                default: cmd = 8'($urandom_range(0, 255));
            endcase
            ready_mode = 1'($urandom_range(0, 1));
            buf_level  = 1'b1;
            repeat ($urandom_range(0, 5)) tick();
            got.delete();
            send_byte(cmd);
            wait_idle(3000);
            repeat (4) tick();
            build_exp(cmd);
            compare_stream($sformatf("rand%0d_cmd%02h", r, cmd));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
